// File: rtl/clock_period_monitor.sv
// Measures period and high time of a clock sampled as data on clk_in; flags period errors and a stuck input.
// Optional DUTY_CHECK_EN adds parameter EXP_HIGH and output duty_err.
module clock_period_monitor #(
    parameter int CNT_W       = 8,
    parameter int EXP_PERIOD  = 28,
    parameter int TOL         = 0,
    parameter int TIMEOUT     = 255,
    parameter int SYNC_STAGES = 2
`ifdef DUTY_CHECK_EN
    ,
    parameter int EXP_HIGH    = 14
`endif
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             mon_in,
    input  logic             enable,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             period_err,
    output logic             stuck,
    output logic [7:0]       meas_count
`ifdef DUTY_CHECK_EN
    ,
    output logic             duty_err
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_ARM, S_HIGH, S_LOW} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX      = '1;
    localparam logic [CNT_W-1:0] CNT_ONE      = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [31:0]      TOL_U        = 32'(TOL);
    localparam logic [31:0]      TIMEOUT_U    = 32'(TIMEOUT);
    localparam logic [31:0]      EXP_PERIOD_U = 32'(EXP_PERIOD);
`ifdef DUTY_CHECK_EN
    localparam logic [31:0]      EXP_HIGH_U   = 32'(EXP_HIGH);
`endif

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_hist;
    state_t                 r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       r_hi;
    logic [CNT_W-1:0]       r_period;
    logic [CNT_W-1:0]       r_high_time;
    logic                   r_meas_valid;
    logic                   r_period_err;
    logic                   r_stuck;
    logic [7:0]             r_meas_count;

    logic                   w_sync;
    logic                   w_rise;
    logic                   w_fall;
    logic                   w_cnt_sat;
    logic [CNT_W-1:0]       w_cnt_inc;
    logic                   w_timeout;
    logic                   w_period_bad;

    // Absolute difference computed on the larger operand first so it never underflows.
    function automatic logic outside_tol(input logic [31:0] val, input logic [31:0] ref_v);
        logic [31:0] diff;
        diff = (val >= ref_v) ? (val - ref_v) : (ref_v - val);
        return diff > TOL_U;
    endfunction

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_hist <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], mon_in};
            r_hist <= r_sync[SYNC_STAGES-1];
        end
    end

    assign w_sync       = r_sync[SYNC_STAGES-1];
    assign w_rise       = w_sync & ~r_hist;
    assign w_fall       = ~w_sync & r_hist;
    assign w_cnt_sat    = (r_cnt == CNT_MAX);
    assign w_cnt_inc    = w_cnt_sat ? r_cnt : r_cnt + CNT_ONE;
    // Timeout fires on the edge where the count would reach TIMEOUT.
    assign w_timeout    = (32'(w_cnt_inc) >= TIMEOUT_U);
    assign w_period_bad = outside_tol(32'(r_cnt), EXP_PERIOD_U) | w_cnt_sat;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_hi         <= '0;
            r_period     <= '0;
            r_high_time  <= '0;
            r_meas_valid <= 1'b0;
            r_period_err <= 1'b0;
            r_stuck      <= 1'b0;
            r_meas_count <= 8'd0;
`ifdef DUTY_CHECK_EN
            duty_err     <= 1'b0;
`endif
        end else begin
            r_meas_valid <= 1'b0;
            if (!enable) begin
                r_state <= S_IDLE;
                r_cnt   <= '0;
                r_stuck <= 1'b0;
`ifdef DUTY_CHECK_EN
                duty_err <= 1'b0;
`endif
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_cnt   <= '0;
                        r_state <= S_ARM;
                    end
                    S_ARM: begin
                        if (w_rise) begin
                            r_cnt   <= CNT_ONE;
                            r_state <= S_HIGH;
                        end else if (w_timeout) begin
                            r_stuck <= 1'b1;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
                    S_HIGH: begin
                        if (w_rise) begin
                            r_cnt <= CNT_ONE;
                        end else if (w_fall) begin
                            r_hi    <= r_cnt;
                            r_cnt   <= w_cnt_inc;
                            r_state <= S_LOW;
                        end else if (w_timeout) begin
                            r_stuck <= 1'b1;
                            r_cnt   <= '0;
                            r_state <= S_ARM;
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
                    S_LOW: begin
                        if (w_rise) begin
                            r_period     <= r_cnt;
                            r_high_time  <= r_hi;
                            r_meas_valid <= 1'b1;
                            r_meas_count <= r_meas_count + 8'd1;
                            r_period_err <= w_period_bad;
                            r_stuck      <= 1'b0;
`ifdef DUTY_CHECK_EN
                            duty_err     <= outside_tol(32'(r_hi), EXP_HIGH_U);
`endif
                            r_cnt        <= CNT_ONE;
                            r_state      <= S_HIGH;
                        end else if (w_timeout) begin
                            r_stuck <= 1'b1;
                            r_cnt   <= '0;
                            r_state <= S_ARM;
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
                    default: begin
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign period     = r_period;
    assign high_time  = r_high_time;
    assign meas_valid = r_meas_valid;
    assign period_err = r_period_err;
    assign stuck      = r_stuck;
    assign meas_count = r_meas_count;

endmodule

// File: tb/tb_clock_period_monitor.sv
// Directed bench for clock_period_monitor: expected measurements are queued as the waveform is driven
// and popped whenever the DUT pulses meas_valid.
module tb_clock_period_monitor;

    logic       clk_in = 1'b0;
    logic       rst_n;
    logic       mon_in;
    logic       enable;
    logic [7:0] period, high_time, meas_count;
    logic       meas_valid, period_err, stuck;
    logic [7:0] tol_period, tol_high_time, tol_meas_count;
    logic       tol_meas_valid, tol_period_err, tol_stuck;
`ifdef DUTY_CHECK_EN
    logic       duty_err, tol_duty_err;
`endif

    typedef struct {
        int         p;
        int         h;
        logic       perr;
        logic       perr_tol;
        logic       duty;
        logic [7:0] cnt;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_count = 8'd0;
    int         last_p = 0;
    int         last_h = 0;

    always #5 clk_in = ~clk_in;

    clock_period_monitor #(
        .CNT_W(8), .EXP_PERIOD(28), .TOL(0), .TIMEOUT(255), .SYNC_STAGES(2)
    ) dut (
        .clk_in(clk_in), .rst_n(rst_n), .mon_in(mon_in), .enable(enable),
        .period(period), .high_time(high_time), .meas_valid(meas_valid),
        .period_err(period_err), .stuck(stuck), .meas_count(meas_count)
`ifdef DUTY_CHECK_EN
        , .duty_err(duty_err)
`endif
    );

    clock_period_monitor #(
        .CNT_W(8), .EXP_PERIOD(28), .TOL(4), .TIMEOUT(255), .SYNC_STAGES(2)
    ) dut_tol (
        .clk_in(clk_in), .rst_n(rst_n), .mon_in(mon_in), .enable(enable),
        .period(tol_period), .high_time(tol_high_time), .meas_valid(tol_meas_valid),
        .period_err(tol_period_err), .stuck(tol_stuck), .meas_count(tol_meas_count)
`ifdef DUTY_CHECK_EN
        , .duty_err(tol_duty_err)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic int absdiff(input int a, input int b);
        return (a > b) ? a - b : b - a;
    endfunction

    task automatic push(input int h, input int l);
        exp_t e;
        e.p        = h + l;
        e.h        = h;
        e.perr     = absdiff(e.p, 28) > 0;
        e.perr_tol = absdiff(e.p, 28) > 4;
        e.duty     = absdiff(h, 14) > 0;
        exp_count  = exp_count + 8'd1;
        e.cnt      = exp_count;
        last_p     = e.p;
        last_h     = e.h;
        sb.push_back(e);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    // n full periods starting with a rise, then a closing rise: n measurements.
    task automatic train(input int h, input int l, input int n);
        for (int k = 0; k <= n; k++) begin
            if (k > 0) push(h, l);
            mon_in = 1'b1;
            if (k == n) break;
            cyc(h);
            mon_in = 1'b0;
            cyc(l);
        end
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk_in);
            n++;
        end
        chk(tag, sb.size(), 0);
    endtask

    task automatic end_phase(input string tag);
        @(negedge clk_in);
        enable = 1'b0;
        @(negedge clk_in);
        mon_in = 1'b0;
        cyc(6);
        chk({tag, "_stuck_clr"}, stuck, 0);
        chk({tag, "_period_hold"}, period, last_p);
        chk({tag, "_count_hold"}, meas_count, exp_count);
`ifdef DUTY_CHECK_EN
        chk({tag, "_duty_clr"}, duty_err, 0);
`endif
    endtask

    always @(negedge clk_in) begin : monitor
        exp_t e;
        if (rst_n === 1'b1 && meas_valid === 1'b1) begin
            chk("meas_expected", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                $display("meas count=%0d period=%0d high=%0d err=%0d", meas_count, period, high_time, period_err);
                chk("period", period, e.p);
                chk("high_time", high_time, e.h);
                chk("period_err", period_err, e.perr);
                chk("meas_count", meas_count, e.cnt);
                chk("stuck_on_meas", stuck, 0);
                chk("tol_valid", tol_meas_valid, 1);
                chk("tol_period_err", tol_period_err, e.perr_tol);
`ifdef DUTY_CHECK_EN
                chk("duty_err", duty_err, e.duty);
`endif
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n  = 1'b0;
        mon_in = 1'b0;
        enable = 1'b0;
        cyc(3);
        chk("rst_period", period, 0);
        chk("rst_high", high_time, 0);
        chk("rst_valid", meas_valid, 0);
        chk("rst_perr", period_err, 0);
        chk("rst_stuck", stuck, 0);
        chk("rst_count", meas_count, 0);
        rst_n = 1'b1;
        cyc(3);

        // 14/14 square: three measurements of 28/14
        enable = 1'b1;
        cyc(2);
        train(14, 14, 3);
        cyc(6);
        drain("p1_drain");
        end_phase("p1");

        // 16/16 square: period 32, error only at TOL=0
        enable = 1'b1;
        cyc(2);
        train(16, 16, 2);
        cyc(6);
        drain("p2_drain");
        end_phase("p2");

        // Input held low: stuck on the 256th edge after enable
        enable = 1'b1;
        repeat (255) @(posedge clk_in);
        #1 chk("stuck_before_timeout", stuck, 0);
        @(posedge clk_in);
        #1 chk("stuck_at_timeout", stuck, 1);
        chk("tol_stuck_at_timeout", tol_stuck, 1);
        @(negedge clk_in);
        mon_in = 1'b1;
        cyc(14);
        mon_in = 1'b0;
        cyc(14);
        chk("stuck_held", stuck, 1);
        push(14, 14);
        mon_in = 1'b1;
        cyc(6);
        drain("p3_drain");
        chk("stuck_cleared", stuck, 0);
        end_phase("p3");

        // 33% duty: 3 high / 6 low
        enable = 1'b1;
        cyc(2);
        train(3, 6, 2);
        cyc(6);
        drain("p4_drain");
        end_phase("p4");

        // enable dropped for 5 cycles in the middle of LOW
        enable = 1'b1;
        cyc(2);
        mon_in = 1'b1;
        cyc(14);
        mon_in = 1'b0;
        cyc(5);
        enable = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk_in);
            #1 chk("gap_valid", meas_valid, 0);
        end
        chk("gap_period", period, last_p);
        chk("gap_high", high_time, last_h);
        chk("gap_count", meas_count, exp_count);
        @(negedge clk_in);
        enable = 1'b1;
        cyc(4);
        train(14, 14, 1);
        cyc(6);
        drain("p5_drain");
        end_phase("p5");

        // Asynchronous reset in the middle of HIGH
        enable = 1'b1;
        cyc(2);
        mon_in = 1'b1;
        cyc(5);
        #2 rst_n = 1'b0;
        #1;
        chk("areset_period", period, 0);
        chk("areset_high", high_time, 0);
        chk("areset_perr", period_err, 0);
        chk("areset_count", meas_count, 0);
        chk("areset_valid", meas_valid, 0);
        chk("areset_stuck", stuck, 0);
        exp_count = 8'd0;
        last_p    = 0;
        last_h    = 0;
        @(negedge clk_in);
        rst_n = 1'b1;
        cyc(14);
        mon_in = 1'b0;
        cyc(14);
        push(14, 14);
        mon_in = 1'b1;
        cyc(6);
        drain("p6_drain");
        end_phase("p6");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
